// File: rtl/pc_fetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch_if
// Purpose  : Jump-control, instruction-memory and decode signals of the fetch unit
// Revision : 1.0
// ============================================================================
interface pc_fetch_if;
  logic [1:0]  JumpOP;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic [31:0] rs_data;
  logic        exec_done;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  modport master (
    input  JumpOP, imm16, jaddr, rs_data, exec_done,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, misalign_err
  );

  modport slave (
    output JumpOP, imm16, jaddr, rs_data, exec_done,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, misalign_err
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : PC register and request/grant/response fetch sequencer
// Revision : 1.0
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  pc_fetch_if.master   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] br_off_w;
  logic [31:0] next_pc_w;

  assign pc_plus4_w = pc_q + 32'd4;
  assign br_off_w   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

  always_comb begin
    next_pc_w = pc_plus4_w;
    case (bus.JumpOP)
      2'd0:    next_pc_w = pc_plus4_w;
      2'd1:    next_pc_w = pc_plus4_w + br_off_w;
      2'd2:    next_pc_w = bus.rs_data;
      default: next_pc_w = {pc_plus4_w[31:28], bus.jaddr, 2'b00};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (bus.imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          // A misaligned register target freezes the PC at the offending jr
          if (bus.JumpOP == 2'd2 && bus.rs_data[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d    = next_pc_w;
            state_d = S_REQ;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.imem_req     = (state_q == S_REQ);
  assign bus.imem_addr    = pc_q;
  assign bus.instr        = instr_q;
  assign bus.instr_valid  = (state_q == S_EXEC);
  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4_w;
  assign bus.misalign_err = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Directed self-checking bench for pc_fetch_unit
// Revision : 1.0
// ============================================================================
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pc_fetch_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_pc",       bus.pc,           32'h0000_0000);
    check("rst_pc_plus4", bus.pc_plus4,     32'h0000_0004);
    check("rst_instr",    bus.instr,        32'h0000_0000);
    check("rst_ivalid",   bus.instr_valid,  32'h0);
    check("rst_req",      bus.imem_req,     32'h0);
    check("rst_addr",     bus.imem_addr,    32'h0000_0000);
    check("rst_misalign", bus.misalign_err, 32'h0);
  endtask

  // Called at a negedge; acts as the memory for one instruction fetch
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                       input int gnt_dly, input int rv_dly, input bit noise,
                       output int req_cyc);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", bus.imem_req, 32'h1);
    req_cyc = cyc;
    check("fetch_addr", bus.imem_addr, exp_addr);
    check("fetch_pc",   bus.pc,        exp_addr);
    for (int i = 0; i < gnt_dly; i++) begin
      bus.imem_rvalid = noise;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("req_hold",  bus.imem_req,  32'h1);
      check("addr_hold", bus.imem_addr, exp_addr);
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    check("wait_noreq", bus.imem_req, 32'h0);
    for (int i = 0; i < rv_dly; i++) begin
      bus.exec_done  = noise;
      bus.imem_rdata = 32'hBAD0_0000;
      @(negedge clk);
      bus.exec_done = 1'b0;
      check("wait_noexec", bus.instr_valid, 32'h0);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    check("exec_valid",  bus.instr_valid, 32'h1);
    check("exec_instr",  bus.instr,       data);
    check("exec_pc",     bus.pc,          exp_addr);
    check("exec_pc4",    bus.pc_plus4,    exp_addr + 32'd4);
  endtask

  task automatic exec(input logic [1:0] op, input logic [15:0] imm,
                      input logic [25:0] ja, input logic [31:0] rs);
    bus.JumpOP    = op;
    bus.imm16     = imm;
    bus.jaddr     = ja;
    bus.rs_data   = rs;
    bus.exec_done = 1'b1;
    @(negedge clk);
    bus.exec_done = 1'b0;
    bus.JumpOP    = 2'd1;
    bus.imm16     = 16'h7FFF;
    bus.jaddr     = 26'h3FF_FFFF;
    bus.rs_data   = 32'h5555_5557;
    check("ivalid_fall", bus.instr_valid, 32'h0);
  endtask

  int t0, t1;

  initial begin
    bus.JumpOP      = 2'd0;
    bus.imm16       = 16'h0;
    bus.jaddr       = 26'h0;
    bus.rs_data     = 32'h0;
    bus.exec_done   = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;

    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    check("idle_noreq", bus.imem_req, 32'h0);
    @(negedge clk);
    check("first_req", bus.imem_req, 32'h1);

    // Sequential fetch, zero-wait memory, 3 cycles per instruction
    fetch(32'h0000_0000, 32'h2000_0001, 0, 0, 0, t0); exec(2'd0, 16'h0, 26'h0, 32'h0);
    fetch(32'h0000_0004, 32'h2000_0002, 0, 0, 0, t1); exec(2'd0, 16'h0, 26'h0, 32'h0);
    check("cpi_0", t1 - t0, 32'd3); t0 = t1;
    fetch(32'h0000_0008, 32'h2000_0003, 0, 0, 0, t1); exec(2'd0, 16'h0, 26'h0, 32'h0);
    check("cpi_1", t1 - t0, 32'd3); t0 = t1;
    fetch(32'h0000_000C, 32'h2000_0004, 0, 0, 0, t1); exec(2'd2, 16'h0, 26'h0, 32'h0000_0100);
    check("cpi_2", t1 - t0, 32'd3);

    // Branches with negative then positive offsets
    fetch(32'h0000_0100, 32'h1000_FFFE, 0, 0, 0, t1); exec(2'd1, 16'hFFFE, 26'h0, 32'h0);
    fetch(32'h0000_00FC, 32'h1000_0003, 0, 0, 0, t1); exec(2'd1, 16'h0003, 26'h0, 32'h0);
    fetch(32'h0000_010C, 32'h0080_0008, 0, 0, 0, t1); exec(2'd2, 16'h0, 26'h0, 32'h4000_0010);

    // Absolute jump keeps pc_plus4[31:28]
    fetch(32'h4000_0010, 32'h0800_0040, 0, 0, 0, t1); exec(2'd3, 16'h0, 26'h000_0040, 32'h0);
    fetch(32'h4000_0100, 32'h03E0_0008, 0, 0, 0, t1); exec(2'd2, 16'h0, 26'h0, 32'hFFFF_FFFC);

    // Sequential wrap past the top of the address space
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, t1); exec(2'd0, 16'h0, 26'h0, 32'h0);
    fetch(32'h0000_0000, 32'h03E0_0009, 0, 0, 0, t1); exec(2'd2, 16'h0, 26'h0, 32'h0000_2000);

    // Backpressure with spurious rvalid in REQ and exec_done pulses in WAIT
    fetch(32'h0000_2000, 32'hCAFE_F00D, 4, 3, 1, t1);
    exec(2'd2, 16'h0, 26'h0, 32'h0000_2002);

    // Misaligned register jump halts
    check("halt_misalign", bus.misalign_err, 32'h1);
    check("halt_pc",       bus.pc,           32'h0000_2000);
    check("halt_req",      bus.imem_req,     32'h0);
    bus.JumpOP    = 2'd0;
    bus.exec_done = 1'b1;
    bus.imem_gnt  = 1'b1;
    repeat (3) @(negedge clk);
    bus.exec_done = 1'b0;
    bus.imem_gnt  = 1'b0;
    check("halt_stay_req",  bus.imem_req,     32'h0);
    check("halt_stay_ival", bus.instr_valid,  32'h0);
    check("halt_stay_pc",   bus.pc,           32'h0000_2000);
    check("halt_stay_err",  bus.misalign_err, 32'h1);

    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);

    // Reset while waiting for a response; the late response must be dropped
    check("rw_req", bus.imem_req, 32'h1);
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    check("rw_wait", bus.imem_req, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rw_pc",    bus.pc,          32'h0000_0000);
    check("rw_idle",  bus.imem_req,    32'h0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBADB_AD00;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    check("rw_ivalid", bus.instr_valid, 32'h0);
    check("rw_instr",  bus.instr,       32'h0000_0000);
    fetch(32'h0000_0000, 32'h1234_5678, 0, 1, 0, t1); exec(2'd0, 16'h0, 26'h0, 32'h0);
    fetch(32'h0000_0004, 32'h8765_4321, 2, 0, 0, t1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
